// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bus between two requesters and the shared ALU arbiter
interface alu_arbiter_if #(parameter int DATA_W = 32);
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [DATA_W-1:0] req_a0, req_b0, req_a1, req_b1, rsp_res;
  logic [3:0] req_op0, req_op1;
  modport master (
    output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
    input  req_ready, rsp_valid, rsp_res
  );
  modport slave (
    input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_res
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two valid/ready requesters
module alu_arbiter #(
  parameter int DATA_W    = 32,
  parameter int PRIO_INIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave bus,
  output logic        busy_o,
  output logic        owner_o,
  output logic [15:0] ops_done_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic prio_q, prio_d, owner_q, owner_d, grant, accept, done;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, alu_res;
  logic [3:0] op_q, op_d;
  logic [15:0] ops_done_q, ops_done_d;
  always_comb begin
    alu_res = op_q == 4'b0000 ? a_q + b_q :
              op_q == 4'b1000 ? a_q - b_q :
              op_q == 4'b0001 ? a_q << b_q[4:0] :
              op_q == 4'b0010 ? {{(DATA_W-1){1'b0}}, $signed(a_q) < $signed(b_q)} :
              op_q == 4'b0011 ? {{(DATA_W-1){1'b0}}, a_q < b_q} : '0;
  end
  // rst gating keeps handshakes quiet while reset is held, not just after it
  always_comb begin
    grant = &bus.req_valid ? prio_q : bus.req_valid[1];
    accept = !rst && state_q == IDLE && |bus.req_valid;
    done = !rst && state_q == RESP && bus.rsp_ready[owner_q];
    bus.req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
    bus.rsp_valid = (!rst && state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    bus.rsp_res = res_q;
    state_d = state_q;
    prio_d = prio_q;
    owner_d = owner_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    res_d = res_q;
    ops_done_d = ops_done_q;
    if (accept) begin
      a_d = grant ? bus.req_a1 : bus.req_a0;
      b_d = grant ? bus.req_b1 : bus.req_b0;
      op_d = grant ? bus.req_op1 : bus.req_op0;
      owner_d = grant;
      prio_d = ~grant;
      state_d = EXEC;
    end
    if (state_q == EXEC) begin
      res_d = alu_res;
      state_d = RESP;
    end
    if (done) begin
      ops_done_d = ops_done_q + 16'd1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q <= PRIO_INIT[0];
      owner_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      res_q <= '0;
      ops_done_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_d;
      owner_q <= owner_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      res_q <= res_d;
      ops_done_q <= ops_done_d;
    end
  end
  assign busy_o = state_q != IDLE;
  assign owner_o = owner_q;
  assign ops_done_o = ops_done_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, latency, hold, operand latching, reset and counter wrap
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, owner;
  logic [15:0] ops_done;
  logic [15:0] exp_ops;
  int n_chk = 0;
  int n_fail = 0;
  alu_arbiter_if #(.DATA_W(32)) bus ();
  alu_arbiter #(.DATA_W(32), .PRIO_INIT(0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy_o(busy), .owner_o(owner), .ops_done_o(ops_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    exp_ops = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_ops_done", ops_done, 0);
    check("rst_res", bus.rsp_res, 0);
  endtask
  task automatic run_op(input logic [1:0] v, input logic [1:0] g, input logic [31:0] res);
    bus.req_valid = v;
    #1;
    check("grant", bus.req_ready, g);
    @(negedge clk);
    check("exec_busy", busy, 1);
    check("exec_ready", bus.req_ready, 0);
    check("exec_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    check("resp_valid", bus.rsp_valid, g);
    check("resp_res", bus.rsp_res, res);
    check("resp_ready", bus.req_ready, 0);
    bus.rsp_ready = g;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    exp_ops = exp_ops + 16'd1;
    check("done_ops", ops_done, exp_ops);
    check("done_rsp_valid", bus.rsp_valid, 0);
  endtask
  initial begin
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req_a0 = 0; bus.req_b0 = 0; bus.req_op0 = 0;
    bus.req_a1 = 0; bus.req_b1 = 0; bus.req_op1 = 0;
    exp_ops = 0;
    do_reset();
    // single ADD
    bus.req_a0 = 3; bus.req_b0 = 5; bus.req_op0 = 4'b0000;
    run_op(2'b01, 2'b01, 8);
    bus.req_valid = 2'b00;
    #1;
    check("idle_res_hold", bus.rsp_res, 8);
    check("idle_busy", busy, 0);
    // alternating grants under contention
    do_reset();
    bus.req_a0 = 3; bus.req_b0 = 5; bus.req_op0 = 4'b1000;
    bus.req_a1 = 1; bus.req_b1 = 2; bus.req_op1 = 4'b0001;
    run_op(2'b11, 2'b01, 32'hFFFF_FFFE);
    check("owner0", owner, 0);
    run_op(2'b11, 2'b10, 4);
    check("owner1", owner, 1);
    run_op(2'b11, 2'b01, 32'hFFFF_FFFE);
    // response backpressure, non-owner rsp_ready ignored
    bus.req_a1 = 32'hFFFF_FFFE; bus.req_b1 = 3; bus.req_op1 = 4'b0010;
    bus.req_valid = 2'b11;
    #1;
    check("slt_grant", bus.req_ready, 2'b10);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", bus.rsp_valid, 2'b10);
      check("hold_res", bus.rsp_res, 1);
      check("hold_ready", bus.req_ready, 0);
      bus.rsp_ready = 2'b01;
      @(negedge clk);
    end
    check("hold_ops", ops_done, exp_ops);
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    exp_ops = exp_ops + 16'd1;
    check("slt_done_ops", ops_done, exp_ops);
    #1;
    check("next_grant0", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    // operands latched on accept only
    bus.req_a0 = 2; bus.req_b0 = 3; bus.req_op0 = 4'b0011;
    bus.req_valid = 2'b01;
    #1;
    check("sltu_grant", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_a0 = 100;
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("sltu_valid", bus.rsp_valid, 2'b01);
    check("sltu_res", bus.rsp_res, 1);
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    exp_ops = exp_ops + 16'd1;
    check("sltu_ops", ops_done, exp_ops);
    // reset during RESP discards the op and restores priority
    bus.req_a0 = 7; bus.req_b0 = 8; bus.req_op0 = 4'b0000;
    bus.req_valid = 2'b01;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_valid", bus.rsp_valid, 2'b01);
    bus.rsp_ready = 2'b01;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", bus.rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", bus.req_ready, 0);
    check("mid_rst_ops", ops_done, 0);
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    rst = 1'b0;
    exp_ops = 0;
    bus.req_a1 = 1; bus.req_b1 = 1; bus.req_op1 = 4'b0000;
    run_op(2'b11, 2'b01, 15);
    bus.req_valid = 2'b00;
    // counter wrap
    force dut.ops_done_q = 16'hFFFF;
    @(negedge clk);
    release dut.ops_done_q;
    @(negedge clk);
    check("preload_ops", ops_done, 16'hFFFF);
    exp_ops = 16'hFFFF;
    run_op(2'b01, 2'b01, 15);
    check("wrap_ops", ops_done, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
